// File: rtl/mul8_seq_if.sv
// Request/response bundle between the control unit and the sequential
// multiplier: start with its operands going in, busy/done/product coming out.
interface mul8_seq_if;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] p;

  modport master (
    output start,
    output a,
    output b,
    input  busy,
    input  done,
    input  p
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    output busy,
    output done,
    output p
  );
endinterface

// File: rtl/mul8_seq.sv
// Sequential 8x8 unsigned shift-and-add multiplier for the Neander ULA.
// One adder8 is reused for eight iterations; the running product lives in
// {acc_hi, acc_lo}, with acc_lo initially holding the multiplier and gradually
// filling with product low bits as the 17-bit {co, sum, acc_lo} shift runs.

// 8-bit ripple-carry adder; the only adder on the multiplier data path.
module adder8 (
  input  logic [7:0] x_i,
  input  logic [7:0] y_i,
  output logic [7:0] s_o,
  output logic       co_o
);
  logic [8:0] carry_s;

  // Bitwise full-adder chain from LSB to MSB.
  always_comb begin
    carry_s = 9'd0;
    s_o     = 8'd0;
    for (int i = 0; i < 8; i++) begin
      s_o[i]       = x_i[i] ^ y_i[i] ^ carry_s[i];
      carry_s[i+1] = (x_i[i] & y_i[i]) | (carry_s[i] & (x_i[i] ^ y_i[i]));
    end
    co_o = carry_s[8];
  end
endmodule

module mul8_seq #(
  parameter logic ZERO_SKIP = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  mul8_seq_if.slave    bus
);
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [7:0]  mcand_q;
  logic [7:0]  acc_hi_q;
  logic [7:0]  acc_lo_q;
  logic [3:0]  cnt_q;
  logic        busy_q;
  logic        done_q;
  logic [15:0] p_q;

  logic [7:0]  addend_s;
  logic [7:0]  sum_s;
  logic        co_s;
  logic        zero_op_s;

  // Partial-product selection: add the multiplicand only when the current
  // multiplier bit (LSB of acc_lo) is set.
  always_comb begin
    if (acc_lo_q[0]) begin
      addend_s = mcand_q;
    end else begin
      addend_s = 8'h00;
    end
  end

  // Zero-operand detection for the optional shortcut straight to DONE.
  always_comb begin
    if (ZERO_SKIP && ((bus.a == 8'h00) || (bus.b == 8'h00))) begin
      zero_op_s = 1'b1;
    end else begin
      zero_op_s = 1'b0;
    end
  end

  adder8 u_adder8 (
    .x_i  (acc_hi_q),
    .y_i  (addend_s),
    .s_o  (sum_s),
    .co_o (co_s)
  );

  // Control FSM plus datapath registers; all outputs are registered so that
  // busy/done/p change only on clock edges. Reset aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mcand_q  <= 8'h00;
      acc_hi_q <= 8'h00;
      acc_lo_q <= 8'h00;
      cnt_q    <= 4'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      p_q      <= 16'h0000;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          if (bus.start) begin
            mcand_q  <= bus.a;
            acc_hi_q <= 8'h00;
            acc_lo_q <= bus.b;
            cnt_q    <= 4'd0;
            if (zero_op_s) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              p_q     <= 16'h0000;
            end else begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          // 17-bit right shift of {co, sum, acc_lo}; the carry lands in acc_hi[7].
          acc_hi_q <= {co_s, sum_s[7:1]};
          acc_lo_q <= {sum_s[0], acc_lo_q[7:1]};
          cnt_q    <= cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            p_q     <= {co_s, sum_s, acc_lo_q[7:1]};
          end else begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.p    = p_q;
endmodule

// File: tb/tb_mul8_seq.sv
// Self-checking bench for mul8_seq: two instances (ZERO_SKIP off and on) see
// identical stimulus; expectations come from plain a*b arithmetic and the
// documented cycle latencies.
module tb_mul8_seq;
  logic clk;
  logic rst;

  mul8_seq_if bus0 ();
  mul8_seq_if bus1 ();

  mul8_seq #(.ZERO_SKIP(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  mul8_seq #(.ZERO_SKIP(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int checks_cnt;
  int errors_cnt;
  logic [15:0] p0_prev;
  logic [15:0] p1_prev;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [7:0] a, input logic [7:0] b);
    bus0.start = s; bus0.a = a; bus0.b = b;
    bus1.start = s; bus1.a = a; bus1.b = b;
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, " d0 busy"}, 32'(bus0.busy), 32'd0);
    chk({tag, " d0 done"}, 32'(bus0.done), 32'd0);
    chk({tag, " d0 p"},    32'(bus0.p),    32'd0);
    chk({tag, " d1 busy"}, 32'(bus1.busy), 32'd0);
    chk({tag, " d1 done"}, 32'(bus1.done), 32'd0);
    chk({tag, " d1 p"},    32'(bus1.p),    32'd0);
  endtask

  // One transaction: start with (ta,tb) and check busy/done/p in every cycle
  // E0+1 .. E0+9 on both instances. If mid>0, a foreign start with a=b=9 is
  // pulsed during cycle mid; operands are scrambled every other cycle.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input int mid, input string tag);
    logic [15:0] exp_p;
    int lat0;
    int lat1;
    exp_p = 16'({8'h00, ta} * {8'h00, tb});
    lat0 = 9;
    lat1 = ((ta == 8'h00) || (tb == 8'h00)) ? 1 : 9;
    drive(1'b1, ta, tb);
    step();
    for (int k = 1; k <= 9; k++) begin
      chk({tag, " d0 busy"}, 32'(bus0.busy), 32'(k < lat0));
      chk({tag, " d0 done"}, 32'(bus0.done), 32'(k == lat0));
      chk({tag, " d0 p"},    32'(bus0.p),    32'((k >= lat0) ? exp_p : p0_prev));
      chk({tag, " d1 busy"}, 32'(bus1.busy), 32'(k < lat1));
      chk({tag, " d1 done"}, 32'(bus1.done), 32'(k == lat1));
      chk({tag, " d1 p"},    32'(bus1.p),    32'((k >= lat1) ? exp_p : p1_prev));
      if (k == mid) begin
        drive(1'b1, 8'd9, 8'd9);
      end else begin
        drive(1'b0, 8'($urandom), 8'($urandom));
      end
      step();
    end
    p0_prev = exp_p;
    p1_prev = exp_p;
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    checks_cnt = 0;
    errors_cnt = 0;
    p0_prev = 16'h0000;
    p1_prev = 16'h0000;

    // Reset held two cycles with start asserted.
    rst = 1'b1;
    drive(1'b1, 8'd5, 8'd7);
    step();
    check_idle_zero("rst1");
    step();
    check_idle_zero("rst2");
    rst = 1'b0;
    drive(1'b0, 8'd0, 8'd0);
    step();
    check_idle_zero("post_rst");

    // Directed cases.
    run_op(8'd13, 8'd11, 0, "13x11");
    run_op(8'hFF, 8'hFF, 0, "FFxFF");
    run_op(8'd3, 8'd5, 3, "3x5_midstart");

    // Reset during RUN cycle 4 aborts the operation.
    drive(1'b1, 8'd7, 8'd6);
    step();
    drive(1'b0, 8'd7, 8'd6);
    step();
    step();
    step();
    chk("abort d0 busy_before", 32'(bus0.busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    p0_prev = 16'h0000;
    p1_prev = 16'h0000;
    check_idle_zero("abort");
    for (int k = 0; k < 10; k++) begin
      step();
      chk("abort d0 no_done", 32'(bus0.done), 32'd0);
      chk("abort d0 p", 32'(bus0.p), 32'd0);
    end
    run_op(8'd7, 8'd6, 0, "7x6_after_rst");

    // Zero operand: shortcut on d1 only.
    run_op(8'd0, 8'd200, 0, "0x200");
    run_op(8'd255, 8'd1, 0, "255x1");
    run_op(8'd200, 8'd0, 0, "200x0");

    // Random sweep.
    for (int n = 0; n < 1000; n++) begin
      ra = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
      rb = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
      run_op(ra, rb, 0, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors_cnt, checks_cnt);
    $finish;
  end
endmodule
